// File: rtl/uart_alici_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_alici_fifo_if
//   Pop-side handshake between the UART receive FIFO and its consumer.
//   The receiver drives the head word, its error flags and the valid strobe;
//   the consumer drives ready. A word leaves the FIFO on any rising edge
//   where valid and ready are both high.
//
//   Signals
//     veri_o          head-of-FIFO data word
//     parite_hata_o   head word was received with a parity error
//     cerceve_hata_o  head word was received with a stop-bit (frame) error
//     veri_gecerli_o  FIFO holds at least one word
//     veri_hazir_i    consumer accepts the head word
//
//   Modports
//     master  receiver side (drives data/flags/valid, reads ready)
//     slave   consumer side (reads data/flags/valid, drives ready)
// -----------------------------------------------------------------------------
interface uart_alici_fifo_if #(
  parameter int VERI_BIT = 8
);

  logic [VERI_BIT-1:0] veri_o;
  logic                parite_hata_o;
  logic                cerceve_hata_o;
  logic                veri_gecerli_o;
  logic                veri_hazir_i;

  modport master (
    output veri_o,
    output parite_hata_o,
    output cerceve_hata_o,
    output veri_gecerli_o,
    input  veri_hazir_i
  );

  modport slave (
    input  veri_o,
    input  parite_hata_o,
    input  cerceve_hata_o,
    input  veri_gecerli_o,
    output veri_hazir_i
  );

endinterface : uart_alici_fifo_if

// File: rtl/uart_alici_fifo.sv
// -----------------------------------------------------------------------------
// uart_alici_fifo
//   UART receiver with a receive FIFO for the peripheral subsystem.
//   Configurable data width, optional even/odd parity and one or two stop
//   bits. The serial line is brought in through a two-flop synchroniser,
//   a start edge is confirmed at mid-bit (short glitches are rejected) and
//   every following bit is sampled at its centre. Received words, including
//   errored ones, are pushed into a first-word-fall-through FIFO together with
//   their parity and frame error flags.
//
//   Parameters
//     VERI_BIT    data bits per frame (5..9)
//     FIFO_DERIN  FIFO depth in words (power of two, >= 2)
//     SAYAC_W     width of the baud divider and bit-timing counter
//
//   Ports
//     clk_i           clock, rising edge
//     rst_i           synchronous active-high reset
//     rx_i            asynchronous serial input, idle high
//     baud_div_i      clock cycles per bit; values below 4 behave as 4
//     parite_mod_i    00/11 no parity, 01 even, 10 odd
//     durak_iki_i     1: two stop bits checked, 0: one
//     pop_if          FIFO head word, flags, valid/ready pop handshake
//     tasma_o         sticky overrun flag (word arrived while FIFO full)
//     hata_temizle_i  clears tasma_o
//     doluluk_o       number of words currently held in the FIFO
// -----------------------------------------------------------------------------
module uart_alici_fifo #(
  parameter int VERI_BIT   = 8,
  parameter int FIFO_DERIN = 8,
  parameter int SAYAC_W    = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              rx_i,
  input  logic [SAYAC_W-1:0]                baud_div_i,
  input  logic [1:0]                        parite_mod_i,
  input  logic                              durak_iki_i,
  uart_alici_fifo_if.master                 pop_if,
  output logic                              tasma_o,
  input  logic                              hata_temizle_i,
  output logic [$clog2(FIFO_DERIN+1)-1:0]   doluluk_o
);

  localparam int PTR_W = $clog2(FIFO_DERIN);
  localparam int CNT_W = $clog2(FIFO_DERIN + 1);

  // Index of the last data bit, sized to the bit counter.
  localparam logic [3:0] SON_BIT = 4'(VERI_BIT - 1);

  typedef enum logic [2:0] {
    HAT_BEKLE,   // wait for the line to be seen high before arming
    BOSTA,       // idle, looking for a falling edge
    BASLA,       // start bit, confirmed at mid-bit
    VERI,        // data bits, LSB first
    PARITE,      // parity bit
    DURAK        // one or two stop bits
  } durum_t;

  typedef struct packed {
    logic [VERI_BIT-1:0] veri;
    logic                pe;
    logic                fe;
  } kelime_t;

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  logic                rx_m;
  logic                rx_s;
  durum_t              durum;
  logic [SAYAC_W-1:0]  sayac;
  logic [3:0]          bit_say;
  logic [SAYAC_W-1:0]  div_l;
  logic [1:0]          par_mod_l;
  logic                iki_l;
  logic [VERI_BIT-1:0] veri_sr;
  logic                par_hata_r;
  logic                cer_hata_r;

  // Word handed to the FIFO one cycle after the final stop-bit sample.
  logic                push_r;
  kelime_t             push_kelime;

  logic [SAYAC_W-1:0]  div_eff;
  logic                yari_zamani;
  logic                bit_zamani;
  logic                par_acik;

  // Dividers below 4 leave too little room for a mid-bit sample point.
  assign div_eff     = (baud_div_i < SAYAC_W'(4)) ? SAYAC_W'(4) : baud_div_i;
  assign yari_zamani = (sayac == (div_l >> 1) - SAYAC_W'(1));
  assign bit_zamani  = (sayac == div_l - SAYAC_W'(1));
  assign par_acik    = (par_mod_l == 2'b01) || (par_mod_l == 2'b10);

  always_ff @(posedge clk_i) begin
    // NOTE: every register in a clocked block is assigned with <= so all of
    // them update together from the values present before the edge.
    if (rst_i) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      durum       <= HAT_BEKLE;
      sayac       <= '0;
      bit_say     <= '0;
      div_l       <= SAYAC_W'(4);
      par_mod_l   <= 2'b00;
      iki_l       <= 1'b0;
      veri_sr     <= '0;
      par_hata_r  <= 1'b0;
      cer_hata_r  <= 1'b0;
      push_r      <= 1'b0;
      push_kelime <= '0;
    end else begin
      rx_m   <= rx_i;
      rx_s   <= rx_m;
      push_r <= 1'b0;

      case (durum)
        HAT_BEKLE: begin
          if (rx_s) durum <= BOSTA;
        end

        BOSTA: begin
          if (!rx_s) begin
            // Configuration is frozen for the whole frame from here on.
            durum     <= BASLA;
            sayac     <= '0;
            div_l     <= div_eff;
            par_mod_l <= parite_mod_i;
            iki_l     <= durak_iki_i;
          end
        end

        BASLA: begin
          if (yari_zamani) begin
            sayac      <= '0;
            bit_say    <= '0;
            cer_hata_r <= 1'b0;
            // A line already back high at mid-start was only a glitch.
            durum      <= rx_s ? BOSTA : VERI;
          end else begin
            sayac <= sayac + SAYAC_W'(1);
          end
        end

        VERI: begin
          if (bit_zamani) begin
            sayac   <= '0;
            veri_sr <= {rx_s, veri_sr[VERI_BIT-1:1]};
            if (bit_say == SON_BIT) begin
              bit_say    <= '0;
              par_hata_r <= 1'b0;
              durum      <= par_acik ? PARITE : DURAK;
            end else begin
              bit_say <= bit_say + 4'd1;
            end
          end else begin
            sayac <= sayac + SAYAC_W'(1);
          end
        end

        PARITE: begin
          if (bit_zamani) begin
            sayac      <= '0;
            // Even mode expects XOR of data and parity bit to be 0, odd mode 1.
            par_hata_r <= (^veri_sr) ^ rx_s ^ (par_mod_l == 2'b10);
            durum      <= DURAK;
          end else begin
            sayac <= sayac + SAYAC_W'(1);
          end
        end

        DURAK: begin
          if (bit_zamani) begin
            sayac <= '0;
            if (!iki_l || bit_say[0]) begin
              push_r           <= 1'b1;
              push_kelime.veri <= veri_sr;
              push_kelime.pe   <= par_hata_r;
              push_kelime.fe   <= cer_hata_r | ~rx_s;
              // A low final stop bit may be a break: rearm only after high.
              durum            <= rx_s ? BOSTA : HAT_BEKLE;
            end else begin
              cer_hata_r <= ~rx_s;
              bit_say    <= 4'd1;
            end
          end else begin
            sayac <= sayac + SAYAC_W'(1);
          end
        end

        default: durum <= HAT_BEKLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  kelime_t            mem [FIFO_DERIN];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   say;

  logic               bos;
  logic               dolu;
  logic               pop;
  logic               push_ok;
  logic               tasma_yeni;

  assign bos        = (say == '0);
  assign dolu       = (say == CNT_W'(FIFO_DERIN));
  assign pop        = !bos && pop_if.veri_hazir_i;
  // A simultaneous pop frees the head slot, so a push into a full FIFO is
  // still accepted in that cycle.
  assign push_ok    = push_r && (!dolu || pop);
  assign tasma_yeni = push_r && dolu && !pop;

  // NOTE: the storage array has no reset; only pointers and count are reset,
  // and outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= push_kelime;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr    <= '0;
      rptr    <= '0;
      say     <= '0;
      tasma_o <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop)     rptr <= rptr + PTR_W'(1);

      case ({push_ok, pop})
        2'b10:   say <= say + CNT_W'(1);
        2'b01:   say <= say - CNT_W'(1);
        default: say <= say;
      endcase

      // A fresh overrun wins over a clear request in the same cycle.
      if (tasma_yeni)          tasma_o <= 1'b1;
      else if (hata_temizle_i) tasma_o <= 1'b0;
    end
  end

  assign doluluk_o             = say;
  assign pop_if.veri_gecerli_o = !bos;
  assign pop_if.veri_o         = bos ? '0 : mem[rptr].veri;
  assign pop_if.parite_hata_o  = bos ? 1'b0 : mem[rptr].pe;
  assign pop_if.cerceve_hata_o = bos ? 1'b0 : mem[rptr].fe;

endmodule : uart_alici_fifo

// File: tb/tb_uart_alici_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_alici_fifo
//   Self-checking bench for uart_alici_fifo (VERI_BIT=8, FIFO_DERIN=4).
//   Frames are built bit by bit on rx_i; a queue-based reference model holds
//   the words the receiver should have buffered, with parity/frame error flags
//   derived from the frame contents, and a sticky overrun flag.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_alici_fifo;

  localparam int VB = 8;
  localparam int FD = 4;
  localparam int SW = 16;

  // Cycles from the start-bit falling edge (driven on a falling clock edge)
  // to the first falling edge where valid is seen, at div=16 with 8N1:
  // 2 synchroniser cycles + 1 idle detect + half bit (8) + 9 bit periods to
  // the stop-bit centre (144) + 1 push cycle.
  localparam int T1_GECIKME = 2 + 1 + 8 + 9 * 16 + 1;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           rx_i;
  logic [SW-1:0]  baud_div_i;
  logic [1:0]     parite_mod_i;
  logic           durak_iki_i;
  logic           tasma_o;
  logic           hata_temizle_i;
  logic [2:0]     doluluk_o;

  uart_alici_fifo_if #(.VERI_BIT(VB)) pop_if ();

  uart_alici_fifo #(
    .VERI_BIT   (VB),
    .FIFO_DERIN (FD),
    .SAYAC_W    (SW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .rx_i           (rx_i),
    .baud_div_i     (baud_div_i),
    .parite_mod_i   (parite_mod_i),
    .durak_iki_i    (durak_iki_i),
    .pop_if         (pop_if.master),
    .tasma_o        (tasma_o),
    .hata_temizle_i (hata_temizle_i),
    .doluluk_o      (doluluk_o)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } kelime_t;

  kelime_t mq[$];
  logic    m_tasma;
  kelime_t son;
  kelime_t atilan;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame on rx_i at 'div' clocks per bit and records in 'son' the
  // word the receiver should report for it. pflip inverts the correct parity
  // bit; s0/s1 are the line levels of the first/second stop bit.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode,
                            input logic two, input logic pflip,
                            input logic s0, input logic s1, input int div);
    logic [15:0] bits;
    int          n;
    int          ones;
    logic        pbit;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n       = 9;
    ones    = $countones(d);
    son.d   = d;
    son.pe  = 1'b0;
    if (mode == 2'b01 || mode == 2'b10) begin
      pbit = (mode == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
      pbit = pbit ^ pflip;
      bits[n] = pbit;
      n++;
      if (mode == 2'b01) son.pe = ((ones + int'(pbit)) % 2) != 0;
      else               son.pe = ((ones + int'(pbit)) % 2) == 0;
    end
    bits[n] = s0;
    n++;
    if (two) begin
      bits[n] = s1;
      n++;
    end
    son.fe = !s0 || (two && !s1);
    for (int i = 0; i < n; i++) begin
      rx_i = bits[i];
      repeat (div) @(negedge clk);
    end
  endtask

  task automatic model_push();
    if (mq.size() < FD) mq.push_back(son);
    else                m_tasma = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_doluluk"}, 32'(doluluk_o), 32'(mq.size()));
    check({tag, "_gecerli"}, 32'(pop_if.veri_gecerli_o), 32'(mq.size() > 0));
    check({tag, "_tasma"}, 32'(tasma_o), 32'(m_tasma));
    if (mq.size() > 0) begin
      check({tag, "_veri"}, 32'(pop_if.veri_o), 32'(mq[0].d));
      check({tag, "_pe"}, 32'(pop_if.parite_hata_o), 32'(mq[0].pe));
      check({tag, "_fe"}, 32'(pop_if.cerceve_hata_o), 32'(mq[0].fe));
    end
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    pop_if.veri_hazir_i = 1'b1;
    @(negedge clk);
    pop_if.veri_hazir_i = 1'b0;
    if (mq.size() > 0) atilan = mq.pop_front();
  endtask

  task automatic set_cfg(input int div, input logic [1:0] mode, input logic two);
    baud_div_i   = SW'(div);
    parite_mod_i = mode;
    durak_iki_i  = two;
  endtask

  // ---------------------------------------------------------------------------
  // Directed and randomised stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int div;
    logic [1:0] mode;
    logic two;

    rst_i               = 1'b1;
    rx_i                = 1'b1;
    hata_temizle_i      = 1'b0;
    pop_if.veri_hazir_i = 1'b0;
    m_tasma             = 1'b0;
    set_cfg(16, 2'b00, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    check_state("reset");
    check("reset_veri", 32'(pop_if.veri_o), 32'h0);
    rst_i = 1'b0;
    idle(5);

    // T1: 8N1 0xA5 with exact valid latency
    fork
      send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
      begin
        repeat (T1_GECIKME - 1) @(negedge clk);
        check("t1_gecerli_once", 32'(pop_if.veri_gecerli_o), 32'h0);
        @(negedge clk);
        check("t1_gecerli_sonra", 32'(pop_if.veri_gecerli_o), 32'h1);
      end
    join
    idle(20);
    model_push();
    pop_one("t1");
    check_state("t1_bos");

    // T2: even parity, 0x03 with parity bit 1; config changes mid-frame ignored
    set_cfg(16, 2'b01, 1'b0);
    fork
      send_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 16);
      begin
        repeat (40) @(negedge clk);
        set_cfg(7, 2'b00, 1'b1);
      end
    join
    idle(20);
    model_push();
    check("t2_pe_beklenen", 32'(son.pe), 32'h1);
    pop_one("t2");
    set_cfg(16, 2'b00, 1'b0);
    idle(10);

    // T3: stop bit 0 then line held low; no new frame until it returns high
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    repeat (40) @(negedge clk);
    model_push();
    check_state("t3_dusuk");
    idle(250);
    check_state("t3_yuksek");
    pop_one("t3");

    // T4: 5-cycle low glitch rejected
    rx_i = 1'b0;
    repeat (5) @(negedge clk);
    idle(100);
    check_state("t4");

    // T5: overrun with depth 4, ordered pops, pop on empty, clear
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k * 8'h11), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
      idle(30);
      model_push();
    end
    check("t5_tasma", 32'(tasma_o), 32'h1);
    for (int k = 0; k < 4; k++) pop_one("t5_pop");
    check_state("t5_bos");
    pop_if.veri_hazir_i = 1'b1;
    repeat (2) @(negedge clk);
    pop_if.veri_hazir_i = 1'b0;
    check_state("t5_bos_pop");
    hata_temizle_i = 1'b1;
    @(negedge clk);
    hata_temizle_i = 1'b0;
    m_tasma = 1'b0;
    check_state("t5_temiz");

    // Full FIFO: push with simultaneous pop is accepted, no overrun
    for (int k = 1; k <= 4; k++) begin
      send_frame(8'(8'h60 + k), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
      idle(30);
      model_push();
    end
    check_state("dolu");
    fork
      send_frame(8'h65, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
      begin
        repeat (T1_GECIKME - 1) @(negedge clk);
        pop_if.veri_hazir_i = 1'b1;
        @(negedge clk);
        pop_if.veri_hazir_i = 1'b0;
      end
    join
    idle(30);
    atilan = mq.pop_front();
    model_push();
    check_state("dolu_push_pop");

    // Full FIFO: overrun in the same cycle as a clear keeps tasma_o set
    fork
      send_frame(8'h66, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
      begin
        repeat (T1_GECIKME - 1) @(negedge clk);
        hata_temizle_i = 1'b1;
        @(negedge clk);
        hata_temizle_i = 1'b0;
      end
    join
    idle(30);
    model_push();
    check_state("tasma_temizle_ayni");
    for (int k = 0; k < 4; k++) pop_one("dolu_bosalt");
    hata_temizle_i = 1'b1;
    @(negedge clk);
    hata_temizle_i = 1'b0;
    m_tasma = 1'b0;

    // T6: reset pulse in the middle of a data bit
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    idle(20);
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    rx_i = 1'b1;
    repeat (16) @(negedge clk);
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    rx_i = 1'b1;
    repeat (8) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    mq.delete();
    m_tasma = 1'b0;
    idle(200);
    check_state("t6_reset");
    set_cfg(16, 2'b01, 1'b1);
    send_frame(8'h5A, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 16);
    idle(30);
    model_push();
    pop_one("t6_5a");

    // Randomised frames: divider (including values below 4), parity mode,
    // stop count, occasional parity/stop corruption, random pops and clears.
    for (int f = 0; f < 16; f++) begin
      div  = int'($urandom_range(4, 20));
      mode = 2'($urandom_range(0, 3));
      two  = 1'($urandom_range(0, 1));
      set_cfg(div, mode, two);
      if ($urandom_range(0, 4) == 0) begin
        div        = 4;
        baud_div_i = SW'($urandom_range(0, 3));
      end
      send_frame(8'($urandom_range(0, 255)), mode, two,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 5) != 0), div);
      idle(3 * div + 10);
      model_push();
      check_state("rnd");
      if ($urandom_range(0, 2) == 0) pop_one("rnd_pop");
      if ($urandom_range(0, 3) == 0) begin
        hata_temizle_i = 1'b1;
        @(negedge clk);
        hata_temizle_i = 1'b0;
        m_tasma = 1'b0;
      end
    end
    while (mq.size() > 0) pop_one("rnd_son");
    check_state("son");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_uart_alici_fifo
